// File: rtl/alu_32b.sv
// alu_32b: single-cycle registered 32-bit ALU, 64-bit result, 16 opcodes.
// Every operation, including MUL and DIV, is computed combinationally from
// a, b and alu_sel, and the selected result is captured in one register.
// Optional feature: define ALU_DIV_EN to build the divider (opcode 3).
// Without it, opcode 3 returns zero and no divider logic exists.
module alu_32b (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  alu_sel,
  output logic [63:0] out
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIV  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_NAND = 4'd7,
    OP_NOR  = 4'd8,
    OP_XNOR = 4'd9,
    OP_SLL  = 4'd10,
    OP_SRL  = 4'd11,
    OP_SRA  = 4'd12,
    OP_ROL  = 4'd13,
    OP_SLT  = 4'd14,
    OP_SLTU = 4'd15
  } alu_op_e;

  alu_op_e     op;
  logic [4:0]  sh;
  logic [32:0] add_r;
  logic [32:0] sub_r;
  logic [63:0] mul_r;
  logic [63:0] div_r;
  logic [31:0] sll_r;
  logic [31:0] srl_r;
  logic [31:0] sra_r;
  logic [63:0] rol_w;
  logic        slt_r;
  logic        sltu_r;
  logic [63:0] res;

  // All 16 encodings are named, so the cast can never produce an undefined value.
  assign op = alu_op_e'(alu_sel);
  assign sh = b[4:0];

  // Arithmetic: 33-bit add/sub keep carry and borrow in bit 32.
  always_comb begin
    add_r = {1'b0, a} + {1'b0, b};
    sub_r = {1'b0, a} - {1'b0, b};
    mul_r = {32'd0, a} * {32'd0, b};
  end

`ifdef ALU_DIV_EN
  // Divider: remainder high, quotient low; divide-by-zero returns {a, all-ones}.
  always_comb begin
    if (b == 32'd0) div_r = {a, 32'hFFFF_FFFF};
    else            div_r = {a % b, a / b};
  end
`else
  // Divider not built: opcode 3 yields zero.
  always_comb begin
    div_r = 64'd0;
  end
`endif

  // Shifts and rotate use only b[4:0]; rotate is the upper half of {a,a} shifted left.
  always_comb begin
    sll_r = a << sh;
    srl_r = a >> sh;
    sra_r = $unsigned($signed(a) >>> sh);
    rol_w = {a, a} << sh;
  end

  // Comparisons.
  always_comb begin
    slt_r  = $signed(a) < $signed(b);
    sltu_r = a < b;
  end

  // Result select; upper bits are zero unless the op defines them.
  always_comb begin
    res = 64'd0;
    case (op)
      OP_ADD:  res = {31'd0, add_r};
      OP_SUB:  res = {31'd0, sub_r};
      OP_MUL:  res = mul_r;
      OP_DIV:  res = div_r;
      OP_AND:  res = {32'd0, a & b};
      OP_OR:   res = {32'd0, a | b};
      OP_XOR:  res = {32'd0, a ^ b};
      OP_NAND: res = {32'd0, ~(a & b)};
      OP_NOR:  res = {32'd0, ~(a | b)};
      OP_XNOR: res = {32'd0, ~(a ^ b)};
      OP_SLL:  res = {32'd0, sll_r};
      OP_SRL:  res = {32'd0, srl_r};
      OP_SRA:  res = {32'd0, sra_r};
      OP_ROL:  res = {32'd0, rol_w[63:32]};
      OP_SLT:  res = {63'd0, slt_r};
      OP_SLTU: res = {63'd0, sltu_r};
      default: res = 64'd0;
    endcase
  end

  // Output register; async reset clears and holds it at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out <= 64'd0;
    else     out <= res;
  end

endmodule

// File: tb/tb_alu_32b.sv
// Directed-vector bench for alu_32b. The driver applies one vector per
// negative edge and pushes its hand-computed expectation; the monitor pops
// one entry after each rising edge and compares.
module tb_alu_32b;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_sel;
  logic [63:0] out;

  typedef struct {
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_32b dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .alu_sel(alu_sel),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Drive one vector at the falling edge and queue its expected result.
  task automatic apply(input string name, input logic [31:0] av, input logic [31:0] bv,
                       input logic [3:0] op, input logic [63:0] exp);
    exp_t e;
    @(negedge clk);
    a = av; b = bv; alu_sel = op;
    e.exp = exp; e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: one result per rising edge while out of reset.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.name, out, e.exp);
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  localparam logic [31:0] SA = 32'h1234ABCD;
  localparam logic [31:0] SB = 32'h00FF00FF;

  initial begin
    logic [63:0] div_sweep, div_a, div_b;
`ifdef ALU_DIV_EN
    div_sweep = 64'h004699DF_00000012;
    div_a     = 64'h00000002_0000000E;
    div_b     = 64'h00000064_FFFFFFFF;
`else
    div_sweep = 64'h0;
    div_a     = 64'h0;
    div_b     = 64'h0;
`endif
    // Reset with X inputs.
    rst = 1'b1; a = 'x; b = 'x; alu_sel = 'x;
    #1;
    check("reset_immediate", out, 64'h0);
    @(posedge clk); #1;
    check("reset_hold", out, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Sweep all opcodes with one operand pair.
    apply("add",  SA, SB, 4'd0,  64'h00000000_1333ACCC);
    apply("sub",  SA, SB, 4'd1,  64'h00000000_1135AACE);
    apply("mul",  SA, SB, 4'd2,  64'h0012228943AA2133);
    apply("div",  SA, SB, 4'd3,  div_sweep);
    apply("and",  SA, SB, 4'd4,  64'h00000000_003400CD);
    apply("or",   SA, SB, 4'd5,  64'h00000000_12FFABFF);
    apply("xor",  SA, SB, 4'd6,  64'h00000000_12CBAB32);
    apply("nand", SA, SB, 4'd7,  64'h00000000_FFCBFF32);
    apply("nor",  SA, SB, 4'd8,  64'h00000000_ED005400);
    apply("xnor", SA, SB, 4'd9,  64'h00000000_ED3454CD);
    apply("sll",  SA, SB, 4'd10, 64'h00000000_80000000);
    apply("srl",  SA, SB, 4'd11, 64'h0);
    apply("sra",  SA, SB, 4'd12, 64'h0);
    apply("rol",  SA, SB, 4'd13, 64'h00000000_891A55E6);
    apply("slt",  SA, SB, 4'd14, 64'h0);
    apply("sltu", SA, SB, 4'd15, 64'h0);

    // Carry, borrow, full product.
    apply("add_carry",  32'hFFFFFFFF, 32'hFFFFFFFF, 4'd0, 64'h00000001_FFFFFFFE);
    apply("sub_borrow", 32'h0,        32'h1,        4'd1, 64'h00000001_FFFFFFFF);
    apply("mul_max",    32'hFFFFFFFF, 32'hFFFFFFFF, 4'd2, 64'hFFFFFFFE_00000001);

    // Signed edges.
    apply("slt_neg",  32'h80000000, 32'h1, 4'd14, 64'h1);
    apply("sltu_neg", 32'h80000000, 32'h1, 4'd15, 64'h0);
    apply("sra_neg",  32'h80000000, 32'h4, 4'd12, 64'h00000000_F8000000);
    apply("rol_wrap", 32'h80000000, 32'h1, 4'd13, 64'h1);
    apply("sll_hi_b", 32'h00000001, 32'hFFFFFFE4, 4'd10, 64'h00000000_00000010);

    // Divide.
    apply("div_100_7", 32'd100, 32'd7, 4'd3, div_a);
    apply("div_by_0",  32'd100, 32'd0, 4'd3, div_b);

    // Let the monitor drain the queue.
    @(posedge clk); #2;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    // Async reset mid-stream: new vector in flight, reset asserted between edges.
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; alu_sel = 4'd2;
    @(posedge clk); #1;
    check("pre_reset_value", out, 64'hFFFFFFFE_00000001);
    a = 32'h1; b = 32'h1; alu_sel = 4'd0;
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_now", out, 64'h0);
    @(posedge clk); #1;
    check("async_reset_hold", out, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    apply("post_reset_add", 32'd5, 32'd6, 4'd0, 64'd11);
    @(posedge clk); #2;
    check("queue_drained_end", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
